// File: rtl/slow_play_interp_if.sv
// Request/stream interface of the slow-play interpolator: DAC-side sample requests,
// source-side fetch handshake and the interpolated output sample.
interface slow_play_interp_if;
   logic [2:0]          ratio;
   logic                interp;
   logic                pause;
   logic                smp_req;
   logic                src_req;
   logic                src_valid;
   logic signed [15:0]  src_data;
   logic signed [15:0]  out_data;
   logic                out_valid;
   logic                overrun;

   modport master (
      output ratio, interp, pause, smp_req, src_valid, src_data,
      input  src_req, out_data, out_valid, overrun
   );

   modport slave (
      input  ratio, interp, pause, smp_req, src_valid, src_data,
      output src_req, out_data, out_valid, overrun
   );
endinterface

// File: rtl/slow_play_interp.sv
// Slow-play sample-rate stretcher: emits N output samples per source sample, either
// holding A or interpolating A + (B-A)*k/N with a fixed 20-cycle serial divide.
module slow_play_interp (
   input  logic                 CLK50,
   input  logic                 RST,
   slow_play_interp_if.slave    bus
);

   typedef enum logic [2:0] {S_PRIME0, S_PRIME1, S_IDLE, S_CALC, S_FETCH} state_t;

   state_t             state, state_nxt;
   logic signed [15:0] a_q, b_q;
   logic [2:0]         k_q;
   logic [3:0]         nl_q;
   logic               interp_q;
   logic               req_sent;
   logic [4:0]         cnt_q;
   logic [19:0]        div_q;
   logic [3:0]         div_r;
   logic               neg_q;

   logic               fetch_state, issue_src, src_take, smp_take, accept, calc_done, span_end;
   logic [3:0]         nl_acc;
   logic signed [16:0] diff;
   logic signed [19:0] prod;
   logic [19:0]        mag;
   logic [4:0]         rem_sh;
   logic               rem_ge;
   logic [3:0]         rem_nxt;
   logic [19:0]        quo_nxt;
   logic [15:0]        delta;
   logic signed [15:0] result;

   // Handshake decode and product setup for the divide loaded at accept time.
   always_comb begin
      fetch_state = (state == S_PRIME0) || (state == S_PRIME1) || (state == S_FETCH);
      issue_src   = fetch_state && !req_sent;
      src_take    = fetch_state && req_sent && bus.src_valid;
      smp_take    = bus.smp_req && !bus.pause;
      accept      = (state == S_IDLE) && smp_take;
      calc_done   = (state == S_CALC) && (cnt_q == 5'd19);
      span_end    = ({1'b0, k_q} == (nl_q - 4'd1));
      nl_acc      = (k_q == 3'd0) ? ({1'b0, bus.ratio} + 4'd1) : nl_q;
      diff        = {b_q[15], b_q} - {a_q[15], a_q};
      prod        = 20'(diff) * 20'($signed({1'b0, k_q}));
      mag         = prod[19] ? (20'd0 - prod) : prod;
   end

   // One restoring-division step per CALC cycle; 20 steps yield the full quotient.
   always_comb begin
      rem_sh  = {div_r, div_q[19]};
      rem_ge  = (rem_sh >= {1'b0, nl_q});
      rem_nxt = rem_ge ? 4'(rem_sh - {1'b0, nl_q}) : rem_sh[3:0];
      quo_nxt = {div_q[18:0], rem_ge};
      // Modulo-2^16 arithmetic is exact because the final sum always fits in 16 bits.
      delta   = neg_q ? (16'd0 - quo_nxt[15:0]) : quo_nxt[15:0];
      result  = (interp_q && (nl_q != 4'd1)) ? (a_q + $signed(delta)) : a_q;
   end

   // NOTE: every combinational output gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_PRIME0: if (src_take)  state_nxt = S_PRIME1;
         S_PRIME1: if (src_take)  state_nxt = S_IDLE;
         S_IDLE:   if (accept)    state_nxt = S_CALC;
         S_CALC:   if (calc_done) state_nxt = span_end ? S_FETCH : S_IDLE;
         S_FETCH:  if (src_take)  state_nxt = S_IDLE;
         default:                 state_nxt = S_PRIME0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         state         <= S_PRIME0;
         a_q           <= '0;
         b_q           <= '0;
         k_q           <= '0;
         nl_q          <= 4'd1;
         interp_q      <= 1'b0;
         req_sent      <= 1'b0;
         cnt_q         <= '0;
         div_q         <= '0;
         div_r         <= '0;
         neg_q         <= 1'b0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.src_req   <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         state         <= state_nxt;
         bus.out_valid <= 1'b0;
         bus.src_req   <= issue_src;

         if (issue_src) req_sent <= 1'b1;
         if (src_take) begin
            req_sent <= 1'b0;
            if (state == S_PRIME0) a_q <= bus.src_data;
            else                   b_q <= bus.src_data;
         end

         if (smp_take && (state != S_IDLE)) bus.overrun <= 1'b1;

         if (accept) begin
            nl_q     <= nl_acc;
            interp_q <= bus.interp;
            div_q    <= mag;
            div_r    <= '0;
            neg_q    <= prod[19];
            cnt_q    <= '0;
         end

         if (state == S_CALC) begin
            cnt_q <= cnt_q + 5'd1;
            div_q <= quo_nxt;
            div_r <= rem_nxt;
            if (calc_done) begin
               bus.out_data  <= result;
               bus.out_valid <= 1'b1;
               if (span_end) begin
                  k_q <= '0;
                  a_q <= b_q;
               end else begin
                  k_q <= k_q + 3'd1;
               end
            end
         end
      end
   end

endmodule
